// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port.
// One request in flight; fixed latency; RISC-V lane handling.
module dmem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [1:0]            store_type,
  input  logic [2:0]            load_type,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam int CNT_I = (LATENCY >= 2) ? (LATENCY - 2) : 0;
  localparam logic [3:0] CNT_INIT = 4'(CNT_I);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       w_accept;
  logic       w_commit;

  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [1:0]            r_st;
  logic [2:0]            r_lt;

  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH];

  logic                  w_sel_in;
  logic                  w_write;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [31:0]           w_wdata;
  logic [1:0]            w_st;
  logic [2:0]            w_lt;
  logic [ADDR_WIDTH-3:0] w_idx;

  logic        w_err;
  logic [3:0]  w_be;
  logic [31:0] w_lane;
  logic [31:0] w_word;
  logic [31:0] w_merged;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ldata;
  logic        w_we;

  // With LATENCY==1 the access commits on the accept edge,
  // so the live inputs are used; otherwise the latched copy.
  always_comb begin
    w_sel_in = (r_state == S_IDLE);
    w_write  = w_sel_in ? req_write  : r_write;
    w_addr   = w_sel_in ? req_addr   : r_addr;
    w_wdata  = w_sel_in ? req_wdata  : r_wdata;
    w_st     = w_sel_in ? store_type : r_st;
    w_lt     = w_sel_in ? load_type  : r_lt;
    w_idx    = w_addr[ADDR_WIDTH-1:2];
  end

  // Next-state, counter and handshake outputs.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    w_accept   = 1'b0;
    w_commit   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_next   = S_RESP;
            w_commit = 1'b1;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next   = S_RESP;
          w_commit = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Alignment / legality check and store byte enables.
  always_comb begin
    w_err  = 1'b0;
    w_be   = 4'b0000;
    w_lane = w_wdata;
    if (w_write) begin
      unique case (w_st)
        2'b00: begin
          w_be   = 4'b0001 << w_addr[1:0];
          w_lane = {4{w_wdata[7:0]}};
        end
        2'b01: begin
          w_lane = {2{w_wdata[15:0]}};
          if (w_addr[0]) w_err = 1'b1;
          else w_be = w_addr[1] ? 4'b1100 : 4'b0011;
        end
        2'b10: begin
          if (w_addr[1:0] != 2'b00) w_err = 1'b1;
          else w_be = 4'b1111;
        end
        default: w_err = 1'b1;
      endcase
    end else begin
      unique case (w_lt)
        3'b000, 3'b100: w_err = 1'b0;
        3'b001, 3'b101: w_err = w_addr[0];
        3'b010:         w_err = (w_addr[1:0] != 2'b00);
        default:        w_err = 1'b1;
      endcase
    end
  end

  // Read-modify-write merge and load extraction.
  always_comb begin
    w_word = r_mem[w_idx];
    for (int i = 0; i < 4; i++) begin
      w_merged[8*i +: 8] = w_be[i] ? w_lane[8*i +: 8]
                                   : w_word[8*i +: 8];
    end
    w_byte  = w_word[{w_addr[1:0], 3'b000} +: 8];
    w_half  = w_addr[1] ? w_word[31:16] : w_word[15:0];
    w_ldata = 32'h0;
    unique case (w_lt)
      3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
      3'b010:  w_ldata = w_word;
      3'b100:  w_ldata = {24'h0, w_byte};
      3'b101:  w_ldata = {16'h0, w_half};
      default: w_ldata = 32'h0;
    endcase
    w_we = w_write && !w_err;
  end

  // FSM state and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Capture the request so later input changes have no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_st    <= 2'b00;
      r_lt    <= 3'b000;
    end else if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_st    <= store_type;
      r_lt    <= load_type;
    end
  end

  // Response registers load on RESP entry and hold until handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_rdata <= (w_write || w_err) ? 32'h0 : w_ldata;
      r_err   <= w_err;
    end else if (resp_valid && resp_ready) begin
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end
  end

  // Array write; contents survive reset, reset blocks a commit.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder.
// Four instances cover LATENCY 1..4 (index d -> LATENCY d+1).
module tb_dmem_responder;

  logic        clk;
  logic        rst        [4];
  logic        req_valid  [4];
  logic        req_ready  [4];
  logic        req_write  [4];
  logic [11:0] req_addr   [4];
  logic [31:0] req_wdata  [4];
  logic [1:0]  store_type [4];
  logic [2:0]  load_type  [4];
  logic        resp_valid [4];
  logic        resp_ready [4];
  logic [31:0] resp_rdata [4];
  logic        resp_err   [4];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(
      .ADDR_WIDTH(12),
      .LATENCY(g + 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .store_type(store_type[g]),
      .load_type (load_type[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request, scramble inputs after accept, wait for response.
  task automatic do_req(input int d, input bit wr,
                        input logic [11:0] a, input logic [31:0] wd,
                        input logic [1:0] st, input logic [2:0] lt,
                        output logic [31:0] rd, output logic er,
                        output int lat, output bit rdy_after);
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    store_type[d] = st;
    load_type[d]  = lt;
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[d]  = 1'b0;
    req_write[d]  = ~wr;
    req_addr[d]   = ~a;
    req_wdata[d]  = ~wd;
    store_type[d] = ~st;
    load_type[d]  = ~lt;
    lat = 0;
    rd = 32'h0;
    er = 1'b0;
    rdy_after = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (resp_valid[d]) begin
        lat = k;
        break;
      end
    end
    if (lat != 0) begin
      rd = resp_rdata[d];
      er = resp_err[d];
      @(posedge clk);
      #1;
      rdy_after = req_ready[d] && !resp_valid[d];
    end
  endtask

  task automatic test_reset(input int d);
    int seen;
    @(negedge clk);
    rst[d]        = 1'b1;
    req_valid[d]  = 1'b1;
    req_write[d]  = 1'b1;
    req_addr[d]   = 12'h050;
    req_wdata[d]  = 32'h0F0F0F0F;
    store_type[d] = 2'b10;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst[d]       = 1'b0;
    req_valid[d] = 1'b0;
    checks++;
    if (req_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_ready L%0d: got %b want 1", d + 1, req_ready[d]);
    end
    checks++;
    if (resp_valid[d] !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp_valid L%0d: got %b want 0", d + 1, resp_valid[d]);
    end
    checks++;
    if (resp_rdata[d] !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata L%0d: got %h want 0", d + 1, resp_rdata[d]);
    end
    checks++;
    if (resp_err[d] !== 1'b0) begin
      errors++;
      $display("FAIL reset_err L%0d: got %b want 0", d + 1, resp_err[d]);
    end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid[d]) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_accept L%0d: got %0d resp cycles want 0", d + 1, seen);
    end
  endtask

  task automatic test_word(input int d);
    logic [31:0] rd;
    logic er;
    int lat;
    bit ra;
    do_req(d, 1, 12'h010, 32'hDEADBEEF, 2'b10, 3'b000, rd, er, lat, ra);
    checks++;
    if (lat != d + 1 || rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL word_sw L%0d: got lat=%0d rd=%h err=%b want lat=%0d rd=0 err=0",
               d + 1, lat, rd, er, d + 1);
    end
    checks++;
    if (!ra) begin
      errors++;
      $display("FAIL word_ready_after L%0d: got 0 want 1", d + 1);
    end
    do_req(d, 0, 12'h010, 32'h0, 2'b00, 3'b010, rd, er, lat, ra);
    checks++;
    if (lat != d + 1 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL word_lw L%0d: got lat=%0d rd=%h err=%b want lat=%0d rd=deadbeef err=0",
               d + 1, lat, rd, er, d + 1);
    end
  endtask

  task automatic test_byte(input int d);
    logic [31:0] rd;
    logic er;
    int lat;
    bit ra;
    do_req(d, 1, 12'h010, 32'h11223344, 2'b10, 3'b000, rd, er, lat, ra);
    do_req(d, 1, 12'h013, 32'hA5A5A580, 2'b00, 3'b000, rd, er, lat, ra);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL byte_sb L%0d: got rd=%h err=%b want 0 0", d + 1, rd, er);
    end
    do_req(d, 0, 12'h013, 32'h0, 2'b00, 3'b000, rd, er, lat, ra);
    checks++;
    if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
      errors++;
      $display("FAIL byte_lb L%0d: got %h want ffffff80", d + 1, rd);
    end
    do_req(d, 0, 12'h013, 32'h0, 2'b00, 3'b100, rd, er, lat, ra);
    checks++;
    if (rd !== 32'h00000080 || er !== 1'b0) begin
      errors++;
      $display("FAIL byte_lbu L%0d: got %h want 00000080", d + 1, rd);
    end
    do_req(d, 0, 12'h010, 32'h0, 2'b00, 3'b010, rd, er, lat, ra);
    checks++;
    if (rd !== 32'h80223344 || er !== 1'b0) begin
      errors++;
      $display("FAIL byte_lw L%0d: got %h want 80223344", d + 1, rd);
    end
  endtask

  task automatic test_half(input int d);
    logic [31:0] rd;
    logic er;
    int lat;
    bit ra;
    do_req(d, 1, 12'h020, 32'h0, 2'b10, 3'b000, rd, er, lat, ra);
    do_req(d, 1, 12'h022, 32'h1234ABCD, 2'b01, 3'b000, rd, er, lat, ra);
    do_req(d, 0, 12'h022, 32'h0, 2'b00, 3'b001, rd, er, lat, ra);
    checks++;
    if (rd !== 32'hFFFFABCD || er !== 1'b0) begin
      errors++;
      $display("FAIL half_lh L%0d: got %h want ffffabcd", d + 1, rd);
    end
    do_req(d, 0, 12'h022, 32'h0, 2'b00, 3'b101, rd, er, lat, ra);
    checks++;
    if (rd !== 32'h0000ABCD || er !== 1'b0) begin
      errors++;
      $display("FAIL half_lhu L%0d: got %h want 0000abcd", d + 1, rd);
    end
    do_req(d, 0, 12'h020, 32'h0, 2'b00, 3'b010, rd, er, lat, ra);
    checks++;
    if (rd !== 32'hABCD0000 || er !== 1'b0) begin
      errors++;
      $display("FAIL half_lw L%0d: got %h want abcd0000", d + 1, rd);
    end
  endtask

  task automatic test_errors(input int d);
    logic [31:0] rd;
    logic er;
    int lat;
    bit ra;
    do_req(d, 1, 12'h030, 32'h01020304, 2'b10, 3'b000, rd, er, lat, ra);
    do_req(d, 1, 12'h031, 32'hCAFEF00D, 2'b10, 3'b000, rd, er, lat, ra);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL err_sw_mis: got rd=%h err=%b want 0 1", rd, er);
    end
    do_req(d, 1, 12'h033, 32'hCAFEF00D, 2'b01, 3'b000, rd, er, lat, ra);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL err_sh_mis: got err=%b want 1", er);
    end
    do_req(d, 1, 12'h030, 32'hFFFFFFFF, 2'b11, 3'b000, rd, er, lat, ra);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL err_st11: got err=%b want 1", er);
    end
    do_req(d, 0, 12'h030, 32'h0, 2'b00, 3'b010, rd, er, lat, ra);
    checks++;
    if (rd !== 32'h01020304 || er !== 1'b0) begin
      errors++;
      $display("FAIL err_word_kept: got %h want 01020304", rd);
    end
    do_req(d, 0, 12'h021, 32'h0, 2'b00, 3'b001, rd, er, lat, ra);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL err_lh_mis: got rd=%h err=%b want 0 1", rd, er);
    end
    do_req(d, 0, 12'h032, 32'h0, 2'b00, 3'b010, rd, er, lat, ra);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL err_lw_mis: got rd=%h err=%b want 0 1", rd, er);
    end
    do_req(d, 0, 12'h010, 32'h0, 2'b00, 3'b011, rd, er, lat, ra);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL err_lt011: got rd=%h err=%b want 0 1", rd, er);
    end
    do_req(d, 0, 12'h031, 32'h0, 2'b00, 3'b100, rd, er, lat, ra);
    checks++;
    if (er !== 1'b0 || rd !== 32'h00000003) begin
      errors++;
      $display("FAIL err_lbu_odd_ok: got rd=%h err=%b want 00000003 0", rd, er);
    end
  endtask

  task automatic test_stall(input int d);
    logic [31:0] rd;
    logic er;
    int lat;
    bit ra;
    bit got;
    do_req(d, 1, 12'h060, 32'h0BADF00D, 2'b10, 3'b000, rd, er, lat, ra);
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_write[d]  = 1'b0;
    req_addr[d]   = 12'h060;
    load_type[d]  = 3'b010;
    resp_ready[d] = 1'b0;
    @(posedge clk);
    #1;
    req_write[d]  = 1'b1;
    req_wdata[d]  = 32'hFFFFFFFF;
    store_type[d] = 2'b10;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp_valid[d]) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || resp_rdata[d] !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL stall_first: got valid=%b rd=%h want 1 0badf00d", got, resp_rdata[d]);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== 32'h0BADF00D ||
          resp_err[d] !== 1'b0 || req_ready[d] !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc%0d: got v=%b rd=%h e=%b rr=%b want 1 0badf00d 0 0",
                 k, resp_valid[d], resp_rdata[d], resp_err[d], req_ready[d]);
      end
    end
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got rr=%b v=%b want 1 0", req_ready[d], resp_valid[d]);
    end
    do_req(d, 0, 12'h060, 32'h0, 2'b00, 3'b010, rd, er, lat, ra);
    checks++;
    if (rd !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL stall_ignored_req: got %h want 0badf00d", rd);
    end
  endtask

  task automatic test_high(input int d);
    logic [31:0] rd;
    logic er;
    int lat;
    bit ra;
    do_req(d, 1, 12'hFFC, 32'h89ABCDEF, 2'b10, 3'b000, rd, er, lat, ra);
    checks++;
    if (er !== 1'b0) begin
      errors++;
      $display("FAIL high_sw: got err=%b want 0", er);
    end
    do_req(d, 0, 12'hFFC, 32'h0, 2'b00, 3'b010, rd, er, lat, ra);
    checks++;
    if (rd !== 32'h89ABCDEF || er !== 1'b0) begin
      errors++;
      $display("FAIL high_lw: got %h want 89abcdef", rd);
    end
    do_req(d, 0, 12'hFFF, 32'h0, 2'b00, 3'b100, rd, er, lat, ra);
    checks++;
    if (rd !== 32'h00000089) begin
      errors++;
      $display("FAIL high_lbu: got %h want 00000089", rd);
    end
    do_req(d, 0, 12'hFFE, 32'h0, 2'b00, 3'b001, rd, er, lat, ra);
    checks++;
    if (rd !== 32'hFFFF89AB) begin
      errors++;
      $display("FAIL high_lh: got %h want ffff89ab", rd);
    end
  endtask

  task automatic test_reset_wins(input int d);
    logic [31:0] rd;
    logic er;
    int lat;
    bit ra;
    int seen;
    do_req(d, 1, 12'h050, 32'hAAAA5555, 2'b10, 3'b000, rd, er, lat, ra);
    @(negedge clk);
    rst[d]        = 1'b1;
    req_valid[d]  = 1'b1;
    req_write[d]  = 1'b1;
    req_addr[d]   = 12'h050;
    req_wdata[d]  = 32'h0F0F0F0F;
    store_type[d] = 2'b10;
    @(negedge clk);
    rst[d]       = 1'b0;
    req_valid[d] = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid[d]) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rstwin_resp L%0d: got %0d resp cycles want 0", d + 1, seen);
    end
    do_req(d, 0, 12'h050, 32'h0, 2'b00, 3'b010, rd, er, lat, ra);
    checks++;
    if (rd !== 32'hAAAA5555) begin
      errors++;
      $display("FAIL rstwin_mem L%0d: got %h want aaaa5555", d + 1, rd);
    end
  endtask

  task automatic test_abort(input int d);
    logic [31:0] rd;
    logic er;
    int lat;
    bit ra;
    int seen;
    bit got;
    do_req(d, 1, 12'h040, 32'h11111111, 2'b10, 3'b000, rd, er, lat, ra);
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_write[d]  = 1'b1;
    req_addr[d]   = 12'h040;
    req_wdata[d]  = 32'h00000005;
    store_type[d] = 2'b10;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_wait: got rr=%b v=%b want 0 0", req_ready[d], resp_valid[d]);
    end
    rst[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0;
    checks++;
    if (req_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready: got %b want 1", req_ready[d]);
    end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid[d]) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_resp: got %0d resp cycles want 0", seen);
    end
    do_req(d, 0, 12'h040, 32'h0, 2'b00, 3'b010, rd, er, lat, ra);
    checks++;
    if (rd !== 32'h11111111 || lat != d + 1) begin
      errors++;
      $display("FAIL abort_mem: got rd=%h lat=%0d want 11111111 %0d", rd, lat, d + 1);
    end
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_write[d]  = 1'b1;
    req_addr[d]   = 12'h044;
    req_wdata[d]  = 32'h00000077;
    store_type[d] = 2'b10;
    resp_ready[d] = 1'b0;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp_valid[d]) begin
        got = 1'b1;
        break;
      end
    end
    rst[d] = 1'b1;
    @(negedge clk);
    rst[d]        = 1'b0;
    resp_ready[d] = 1'b1;
    checks++;
    if (!got || resp_valid[d] !== 1'b0 || resp_rdata[d] !== 32'h0) begin
      errors++;
      $display("FAIL resp_rst_drop: got seen=%b v=%b rd=%h want 1 0 0",
               got, resp_valid[d], resp_rdata[d]);
    end
    do_req(d, 0, 12'h044, 32'h0, 2'b00, 3'b010, rd, er, lat, ra);
    checks++;
    if (rd !== 32'h00000077) begin
      errors++;
      $display("FAIL resp_rst_committed: got %h want 00000077", rd);
    end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      rst[d]        = 1'b1;
      req_valid[d]  = 1'b0;
      req_write[d]  = 1'b0;
      req_addr[d]   = 12'h0;
      req_wdata[d]  = 32'h0;
      store_type[d] = 2'b00;
      load_type[d]  = 3'b000;
      resp_ready[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) rst[d] = 1'b0;

    for (int d = 0; d < 4; d++) test_reset(d);
    test_word(1);
    test_byte(1);
    test_half(1);
    test_errors(1);
    test_stall(1);
    test_high(1);
    test_word(0);
    test_byte(0);
    test_half(0);
    test_reset_wins(0);
    test_word(3);
    test_byte(3);
    test_half(3);
    test_abort(2);
    test_reset_wins(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
